// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encodings, BCD limits and digit-increment helpers for the time counter
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

  localparam logic [3:0] SEC_T_MAX      = 4'd5;
  localparam logic [3:0] MIN_T_MAX      = 4'd5;
  localparam logic [3:0] HR_T_MAX       = 4'd2;
  localparam logic [3:0] HR_U_MAX_AT_2  = 4'd3;
  localparam logic [3:0] DIGIT_MAX      = 4'd9;

  typedef struct packed {
    logic [3:0] t_hours;
    logic [3:0] hours;
    logic [3:0] t_mins;
    logic [3:0] minutes;
    logic [3:0] t_secs;
    logic [3:0] seconds;
  } time_t;

  function automatic time_t bcd_inc_hours(input time_t t);
    time_t r;
    r = t;
    if (t.t_hours == HR_T_MAX && t.hours == HR_U_MAX_AT_2) begin
      r.t_hours = 4'd0;
      r.hours   = 4'd0;
    end else if (t.hours == DIGIT_MAX) begin
      r.hours   = 4'd0;
      r.t_hours = t.t_hours + 4'd1;
    end else begin
      r.hours = t.hours + 4'd1;
    end
    return r;
  endfunction

  // carry_out selects whether a 59->00 wrap ripples into the hours digits
  function automatic time_t bcd_inc_minutes(input time_t t, input logic carry_out);
    time_t r;
    r = t;
    if (t.minutes != DIGIT_MAX) begin
      r.minutes = t.minutes + 4'd1;
    end else begin
      r.minutes = 4'd0;
      if (t.t_mins != MIN_T_MAX) begin
        r.t_mins = t.t_mins + 4'd1;
      end else begin
        r.t_mins = 4'd0;
        if (carry_out) r = bcd_inc_hours(r);
      end
    end
    return r;
  endfunction

  function automatic time_t bcd_advance(input time_t t);
    time_t r;
    r = t;
    if (t.seconds != DIGIT_MAX) begin
      r.seconds = t.seconds + 4'd1;
    end else begin
      r.seconds = 4'd0;
      if (t.t_secs != SEC_T_MAX) begin
        r.t_secs = t.t_secs + 4'd1;
      end else begin
        r.t_secs = 4'd0;
        r = bcd_inc_minutes(r, 1'b1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_counter_if.sv
// rtl/bcd_time_counter_if.sv - display-side bundle: six BCD digits, seconds tick and current mode
interface bcd_time_counter_if;

  logic [3:0] seconds;
  logic [3:0] t_secs;
  logic [3:0] minutes;
  logic [3:0] t_mins;
  logic [3:0] hours;
  logic [3:0] t_hours;
  logic       sec_tick;
  logic [1:0] mode;

  modport master (
    output seconds, t_secs, minutes, t_mins, hours, t_hours, sec_tick, mode
  );

  modport slave (
    input seconds, t_secs, minutes, t_mins, hours, t_hours, sec_tick, mode
  );

endinterface

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer with rising-edge detect; one pulse per press
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      prev_q <= sync_q[1];
    end
  end

  // Combinational pulse so the action lands on the third edge after the input rises
  assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - 1 Hz prescaler, cascaded 24-hour BCD counter and hour/minute set FSM
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_mode,
  input  logic                 btn_inc,
  bcd_time_counter_if.master   disp
);

  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(CLK_HZ - 1);

  logic             mode_p;
  logic             inc_p;
  mode_e            state_q, state_d;
  time_t            time_q, time_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;

  btn_sync_edge u_mode_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .pulse (mode_p)
  );

  btn_sync_edge u_inc_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_inc),
    .pulse (inc_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MODE_RUN;
      time_q  <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // A mode pulse always takes priority; the inc pulse on that cycle is dropped
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    unique case (state_q)
      MODE_RUN: begin
        if (mode_p) begin
          state_d = MODE_SET_HR;
          presc_d = '0;
        end else if (presc_q == PRE_MAX) begin
          presc_d = '0;
          time_d  = bcd_advance(time_q);
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end
      MODE_SET_HR: begin
        presc_d = '0;
        if (mode_p) begin
          state_d = MODE_SET_MIN;
        end else if (inc_p) begin
          time_d = bcd_inc_hours(time_q);
        end
      end
      MODE_SET_MIN: begin
        if (mode_p) begin
          state_d        = MODE_RUN;
          time_d.seconds = 4'd0;
          time_d.t_secs  = 4'd0;
          presc_d        = '0;
        end else if (inc_p) begin
          time_d = bcd_inc_minutes(time_q, 1'b0);
        end
      end
      default: begin
        state_d = MODE_RUN;
      end
    endcase
  end

  assign disp.seconds  = time_q.seconds;
  assign disp.t_secs   = time_q.t_secs;
  assign disp.minutes  = time_q.minutes;
  assign disp.t_mins   = time_q.t_mins;
  assign disp.hours    = time_q.hours;
  assign disp.t_hours  = time_q.t_hours;
  assign disp.sec_tick = tick_q;
  assign disp.mode     = state_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - directed and randomized checks of bcd_time_counter against a seconds-of-day model
module tb_bcd_time_counter;

  localparam int HZ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;

  bcd_time_counter_if u_if ();

  bcd_time_counter #(.CLK_HZ(HZ), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .disp     (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: time as seconds-of-day, mode 0/1/2, prescaler count, button sample history
  int       m_tsec = 0;
  int       m_md = 0;
  int       m_pre = 0;
  bit       m_tick = 1'b0;
  bit [2:0] m_hm = 3'b000;
  bit [2:0] m_hi = 3'b000;

  function automatic void model_edge(input int tsec, input int md, input int pre,
                                     input bit mp, input bit ip,
                                     output int ntsec, output int nmd, output int npre,
                                     output bit ntick);
    int hr, mn;
    ntsec = tsec; nmd = md; npre = pre; ntick = 1'b0;
    case (md)
      0: begin
        if (mp) begin
          nmd = 1; npre = 0;
        end else if (pre == HZ - 1) begin
          npre = 0; ntsec = (tsec + 1) % 86400; ntick = 1'b1;
        end else begin
          npre = pre + 1;
        end
      end
      1: begin
        npre = 0;
        if (mp) nmd = 2;
        else if (ip) begin
          hr = (tsec / 3600 + 1) % 24;
          ntsec = hr * 3600 + tsec % 3600;
        end
      end
      default: begin
        if (mp) begin
          nmd = 0; npre = 0; ntsec = tsec - tsec % 60;
        end else if (ip) begin
          mn = ((tsec / 60) % 60 + 1) % 60;
          ntsec = (tsec / 3600) * 3600 + mn * 60 + tsec % 60;
        end
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_proc
    int nt, nm, np;
    bit nk;
    if (!rst_n) begin
      m_tsec <= 0; m_md <= 0; m_pre <= 0; m_tick <= 1'b0;
      m_hm <= 3'b000; m_hi <= 3'b000;
    end else begin
      model_edge(m_tsec, m_md, m_pre, m_hm[1] & ~m_hm[2], m_hi[1] & ~m_hi[2], nt, nm, np, nk);
      m_tsec <= nt; m_md <= nm; m_pre <= np; m_tick <= nk;
      m_hm <= {m_hm[1:0], btn_mode};
      m_hi <= {m_hi[1:0], btn_inc};
    end
  end

  function automatic logic [26:0] model_vec(input int tsec, input int md, input bit tick);
    int h, m, s;
    h = tsec / 3600; m = (tsec / 60) % 60; s = tsec % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), tick, 2'(md)};
  endfunction

  wire [23:0] digits = {u_if.t_hours, u_if.hours, u_if.t_mins, u_if.minutes, u_if.t_secs, u_if.seconds};
  wire [26:0] dut_vec = {digits, u_if.sec_tick, u_if.mode};

  task automatic cyc();
    @(negedge clk);
    check("cycle", dut_vec, model_vec(m_tsec, m_md, m_tick));
  endtask

  task automatic press(input bit is_mode);
    if (is_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
    repeat (3) cyc();
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, ticks;
    repeat (2) @(negedge clk);
    check("rst_digits", digits, 24'h0);
    check("rst_mode", u_if.mode, 2'b00);
    check("rst_tick", u_if.sec_tick, 1'b0);
    rst_n = 1'b1;

    n = 0;
    do begin cyc(); n++; end while (!u_if.sec_tick && n < 10);
    check("first_tick_latency", n, HZ);
    check("first_tick_seconds", u_if.seconds, 4'd1);

    repeat (9 * HZ) cyc();
    check("ten_ticks", digits, 24'h000010);
    repeat (50 * HZ) cyc();
    check("sixty_ticks", digits, 24'h000100);

    do_reset();
    press(1'b1);
    check("enter_set_hr", u_if.mode, 2'b01);
    repeat (23) press(1'b0);
    check("hours_23", {u_if.t_hours, u_if.hours}, 8'h23);
    press(1'b1);
    check("enter_set_min", u_if.mode, 2'b10);
    repeat (59) press(1'b0);
    check("minutes_59", {u_if.t_mins, u_if.minutes}, 8'h59);
    press(1'b1);
    check("back_to_run", u_if.mode, 2'b00);
    check("time_235900", digits, 24'h235900);
    ticks = 0;
    repeat (60 * HZ) begin cyc(); if (u_if.sec_tick) ticks++; end
    check("rollover_ticks", ticks, 60);
    check("rollover_time", digits, 24'h000000);

    press(1'b1);
    repeat (24) press(1'b0);
    check("hr_wrap_24", {u_if.t_hours, u_if.hours}, 8'h00);
    check("hr_wrap_min_kept", {u_if.t_mins, u_if.minutes}, 8'h00);
    repeat (5) press(1'b0);
    check("hours_05", {u_if.t_hours, u_if.hours}, 8'h05);
    press(1'b1);
    repeat (59) press(1'b0);
    press(1'b0);
    check("min_wrap", {u_if.t_mins, u_if.minutes}, 8'h00);
    check("min_wrap_no_carry", {u_if.t_hours, u_if.hours}, 8'h05);
    press(1'b1);
    check("run_again", u_if.mode, 2'b00);

    btn_mode = 1'b1; btn_inc = 1'b1;
    repeat (3) cyc();
    check("simul_mode", u_if.mode, 2'b01);
    check("simul_hours", {u_if.t_hours, u_if.hours}, 8'h05);
    repeat (17) cyc();
    check("held_mode", u_if.mode, 2'b01);
    check("held_hours", {u_if.t_hours, u_if.hours}, 8'h05);
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) cyc();
    press(1'b1);
    press(1'b1);

    repeat (600) begin
      if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 2) == 0) btn_inc = ~btn_inc;
      cyc();
    end
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (4) cyc();

    do_reset();
    press(1'b1);
    repeat (12) press(1'b0);
    press(1'b1);
    repeat (34) press(1'b0);
    press(1'b1);
    n = 0;
    while (digits[7:0] != 8'h56 && n < 400) begin cyc(); n++; end
    check("reach_123456", digits, 24'h123456);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_digits", digits, 24'h0);
    check("async_rst_tick", u_if.sec_tick, 1'b0);
    check("async_rst_mode", u_if.mode, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
